// File: rtl/burst_count_monitor_pkg.sv
// Shared types and defaults for the burst count monitor.
// Optional input synchronizer is selected with BURST_MON_SYNC_EN.
package burst_mon_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COUNTING = 2'd2,
    DONE     = 2'd3
  } mon_state_t;

  localparam int IDLE_CNT_W   = 8;
  localparam int CW_DEF       = 4;
  localparam int IDLE_CYC_DEF = 4;

endpackage

// File: rtl/burst_count_monitor_if.sv
// Control/result bundle between a bring-up harness (master) and the monitor (slave).
interface burst_count_monitor_if #(
  parameter int CW = burst_mon_pkg::CW_DEF
);

  logic          arm;
  logic          step_in;
  logic          count_ack;
  logic [CW-1:0] count_out;
  logic          count_valid;
  logic          overflow;
  logic          busy;

  modport master (
    output arm, step_in, count_ack,
    input  count_out, count_valid, overflow, busy
  );

  modport slave (
    input  arm, step_in, count_ack,
    output count_out, count_valid, overflow, busy
  );

endinterface

// File: rtl/burst_count_monitor_rise_edge_detect.sv
// Rising-edge detector on the step line; BURST_MON_SYNC_EN inserts a
// 2-flop synchronizer ahead of the edge register.
module rise_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic step_in,
  output logic step_edge
);

  logic step_s;
  logic prev_r;

`ifdef BURST_MON_SYNC_EN
  logic [1:0] sync_r;

  // Two-stage synchronizer for asynchronous pulse sources
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], step_in};
    end
  end

  assign step_s = sync_r[1];
`else
  assign step_s = step_in;
`endif

  // Previous-sample register for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= step_s;
    end
  end

  assign step_edge = step_s & ~prev_r;

endmodule

// File: rtl/burst_count_monitor.sv
// Counts step edges within one burst, ends the burst after IDLE_CYC quiet cycles
// and presents the count with valid/ack. Optional macro: BURST_MON_SYNC_EN.
module burst_count_monitor
  import burst_mon_pkg::*;
#(
  parameter int CW       = CW_DEF,
  parameter int IDLE_CYC = IDLE_CYC_DEF
) (
  input logic                  clk,
  input logic                  rst,
  burst_count_monitor_if.slave bus
);

  localparam logic [CW-1:0]         CNT_MAX    = {CW{1'b1}};
  localparam logic [IDLE_CNT_W-1:0] IDLE_LIMIT = IDLE_CNT_W'(IDLE_CYC);

  mon_state_t            state_r;
  logic [CW-1:0]         count_r;
  logic [IDLE_CNT_W-1:0] idle_r;
  logic [IDLE_CNT_W-1:0] idle_inc_s;
  logic                  ovf_r;
  logic                  valid_r;
  logic                  busy_r;
  logic                  step_edge_s;

  rise_edge_detect u_edge (
    .clk       (clk),
    .rst       (rst),
    .step_in   (bus.step_in),
    .step_edge (step_edge_s)
  );

  assign idle_inc_s = idle_r + IDLE_CNT_W'(1);

  // Burst FSM with step/idle counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= '0;
      idle_r  <= '0;
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.arm) begin
            state_r <= ARMED;
            count_r <= '0;
            ovf_r   <= 1'b0;
            idle_r  <= '0;
          end
        end
        ARMED: begin
          if (!bus.arm) begin
            state_r <= IDLE;
          end else if (step_edge_s) begin
            state_r <= COUNTING;
            count_r <= CW'(1);
            idle_r  <= '0;
            busy_r  <= 1'b1;
          end
        end
        COUNTING: begin
          // Abort beats everything; an edge beats the idle timeout
          if (!bus.arm) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (step_edge_s) begin
            idle_r <= '0;
            if (count_r == CNT_MAX) begin
              ovf_r <= 1'b1;
            end else begin
              count_r <= count_r + CW'(1);
            end
          end else if (idle_inc_s == IDLE_LIMIT) begin
            state_r <= DONE;
            idle_r  <= '0;
            valid_r <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            idle_r <= idle_inc_s;
          end
        end
        DONE: begin
          if (bus.count_ack) begin
            valid_r <= 1'b0;
            if (bus.arm) begin
              state_r <= ARMED;
              count_r <= '0;
              ovf_r   <= 1'b0;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          idle_r  <= '0;
        end
      endcase
    end
  end

  assign bus.count_out   = count_r;
  assign bus.count_valid = valid_r;
  assign bus.overflow    = ovf_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_burst_count_monitor.sv
// Scoreboard bench for burst_count_monitor; honours BURST_MON_SYNC_EN latency.
module tb_burst_count_monitor;

  localparam int CW       = 4;
  localparam int IDLE_CYC = 4;
`ifdef BURST_MON_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct packed {
    logic [CW-1:0] count;
    logic          ovf;
  } exp_t;

  exp_t sb_q[$];
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_edge_cyc = 0;

  burst_count_monitor_if #(.CW(CW)) bus ();

  burst_count_monitor #(.CW(CW), .IDLE_CYC(IDLE_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse(input int lows);
    bus.step_in = 1'b1;
    tick();
    last_edge_cyc = cyc;
    bus.step_in = 1'b0;
    repeat (lows) tick();
  endtask

  task automatic push_burst(input int n);
    exp_t e;
    e.count = (n > 15) ? 4'd15 : n[CW-1:0];
    e.ovf   = (n > 15);
    sb_q.push_back(e);
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus.count_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic ack(input logic arm_after);
    bus.arm = arm_after;
    bus.count_ack = 1'b1;
    tick();
    bus.count_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checks++; if (bus.count_out !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count_out); end
    checks++; if (bus.count_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.count_valid); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.overflow); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_nominal();
    bit   seen;
    exp_t e;
    int   lat;
    bus.arm = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) pulse(1);
    push_burst(8);
    wait_valid(seen);
    lat = cyc - last_edge_cyc;
    checks++; if (!seen) begin errors++; $display("FAIL nominal_timeout: got valid=0 expected 1"); end
    checks++; if (lat !== IDLE_CYC + SYNC_LAT) begin errors++; $display("FAIL nominal_latency: got %0d expected %0d", lat, IDLE_CYC + SYNC_LAT); end
    e = sb_q.pop_front();
    checks++; if (bus.count_out !== e.count) begin errors++; $display("FAIL nominal_count: got %0d expected %0d", bus.count_out, e.count); end
    checks++; if (bus.overflow !== e.ovf) begin errors++; $display("FAIL nominal_ovf: got %b expected %b", bus.overflow, e.ovf); end
    ack(1'b1);
    checks++; if (bus.count_valid !== 1'b0) begin errors++; $display("FAIL nominal_ack_valid: got %b expected 0", bus.count_valid); end
    checks++; if (bus.count_out !== 4'd0) begin errors++; $display("FAIL nominal_armed_clear: got %0d expected 0", bus.count_out); end
  endtask

  task automatic test_saturation();
    bit   seen;
    exp_t e;
    for (int i = 0; i < 20; i++) pulse(1);
    push_burst(20);
    wait_valid(seen);
    checks++; if (!seen) begin errors++; $display("FAIL sat_timeout: got valid=0 expected 1"); end
    e = sb_q.pop_front();
    checks++; if (bus.count_out !== e.count) begin errors++; $display("FAIL sat_count: got %0d expected %0d", bus.count_out, e.count); end
    checks++; if (bus.overflow !== e.ovf) begin errors++; $display("FAIL sat_ovf: got %b expected %b", bus.overflow, e.ovf); end
    ack(1'b1);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL sat_ovf_clear: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_idle_boundary();
    bit   seen;
    exp_t e;
    // Rise on the 4th idle cycle keeps the burst alive
    for (int i = 0; i < 3; i++) pulse(3);
    pulse(1);
    push_burst(4);
    wait_valid(seen);
    e = sb_q.pop_front();
    checks++; if (!seen || bus.count_out !== e.count) begin errors++; $display("FAIL idle_join: got %0d expected %0d", bus.count_out, e.count); end
    ack(1'b1);
    // Rise one cycle later lands in DONE and is dropped
    pulse(1);
    pulse(1);
    pulse(4);
    pulse(1);
    pulse(1);
    push_burst(3);
    wait_valid(seen);
    e = sb_q.pop_front();
    checks++; if (!seen || bus.count_out !== e.count) begin errors++; $display("FAIL idle_split: got %0d expected %0d", bus.count_out, e.count); end
    ack(1'b1);
  endtask

  task automatic test_handshake_hold();
    bit   seen;
    exp_t e;
    pulse(1);
    pulse(1);
    push_burst(2);
    wait_valid(seen);
    e = sb_q.pop_front();
    checks++; if (!seen || bus.count_out !== e.count) begin errors++; $display("FAIL hold_count: got %0d expected %0d", bus.count_out, e.count); end
    for (int i = 0; i < 10; i++) begin
      bus.step_in = i[0] ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (bus.count_valid !== 1'b1 || bus.count_out !== e.count) begin
        errors++;
        $display("FAIL hold_cycle%0d: got valid=%b count=%0d expected valid=1 count=%0d", i, bus.count_valid, bus.count_out, e.count);
      end
    end
    bus.step_in = 1'b0;
    tick();
    ack(1'b0);
    checks++; if (bus.count_valid !== 1'b0) begin errors++; $display("FAIL hold_ack_valid: got %b expected 0", bus.count_valid); end
    pulse(1);
    pulse(1);
    repeat (SYNC_LAT + 1) tick();
    checks++; if (bus.busy !== 1'b0 || bus.count_out !== e.count) begin errors++; $display("FAIL hold_idle: got busy=%b count=%0d expected busy=0 count=%0d", bus.busy, bus.count_out, e.count); end
  endtask

  task automatic test_abort();
    bit rose;
    bus.arm = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) pulse(1);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre: got %b expected 1", bus.busy); end
    bus.arm = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    rose = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.count_valid !== 1'b0) rose = 1'b1;
      tick();
    end
    checks++; if (rose) begin errors++; $display("FAIL abort_valid: got 1 expected 0"); end
  endtask

  task automatic test_reset_mid_burst();
    bus.arm = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) pulse(1);
    repeat (2) tick();
    checks++; if (bus.overflow !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got ovf=%b busy=%b expected 1 1", bus.overflow, bus.busy); end
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.count_out, bus.count_valid, bus.overflow, bus.busy} !== 7'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got count=%0d valid=%b ovf=%b busy=%b expected all 0", bus.count_out, bus.count_valid, bus.overflow, bus.busy);
    end
    rst = 1'b0;
    bus.arm = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.arm = 1'b0;
    bus.step_in = 1'b0;
    bus.count_ack = 1'b0;
    test_reset();
    test_nominal();
    test_saturation();
    test_idle_boundary();
    test_handshake_hold();
    test_abort();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/burst_count_monitor.md
# burst_count_monitor

Board-test receiver that pairs with the gated-clock burst generator. It watches a step line in the system clock domain, counts rising edges within one burst, and declares the burst ended after a programmable idle gap. It then presents the count with a valid/acknowledge handshake, so a bring-up harness can confirm that exactly the expected number of cycles reached the MIPS core.

## Interface
- `CW`, default 4: count width; the count saturates at 2^CW−1.
- `IDLE_CYC`, default 4: consecutive edge-free `clk` cycles that end a burst; legal range 1..255.
- `clk`, in, 1: system clock; all logic on posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `arm`, in, 1: level; high enables capture of the next burst.
- `step_in`, in, 1: observed step/pulse line; each 0→1 transition is one step.
- `count_out`, out, CW: captured step count; stable while `count_valid` is high.
- `count_valid`, out, 1: result available.
- `count_ack`, in, 1: consumer accepts the result; only meaningful while `count_valid` is high.
- `overflow`, out, 1: the current or last burst exceeded 2^CW−1 steps.
- `busy`, out, 1: high in COUNTING.

## Operation
- Edge detect: `prev` register samples `step_in` every cycle. `edge = step_in & ~prev`. `prev` resets to 0.
- FSM states:
  - IDLE: wait for `arm`; go to ARMED when `arm`=1.
  - ARMED: clear the count and `overflow`; wait for the first edge.
  - COUNTING: accumulate steps; end on idle timeout.
  - DONE: present the result until acknowledged.
- IDLE→ARMED when `arm`=1.
- ARMED→COUNTING on `edge`. That edge counts: count=1, idle counter=0.
- COUNTING:
  - Each `edge` increments the count. At 2^CW−1 the count holds and `overflow` sets; `overflow` stays set until the next ARMED entry.
  - The idle counter resets on `edge` and otherwise increments.
  - When the idle counter reaches IDLE_CYC, go to DONE.
- DONE: `count_valid`=1 and edges are ignored. On `count_ack`, go to ARMED if `arm`=1, else IDLE.
- `arm`=0 in ARMED or COUNTING aborts to IDLE next cycle. The count is discarded and no `count_valid` is raised.
- `arm`=0 in DONE has no effect; the result waits for `count_ack`.
- `count_ack` outside DONE is ignored.
- Idle counter width is 8 bits. It compares with `==` and cannot wrap before matching.

## Timing
- Reset values: state=IDLE, `count_out`=0, `count_valid`=0, `overflow`=0, `busy`=0, `prev`=0, idle counter=0.
- Edge latency: `step_in` rises in cycle t; the count is updated at the end of cycle t.
- End-of-burst latency: the last edge is at cycle t; `count_valid` rises at cycle t+IDLE_CYC+1.
- Handshake: `count_valid` and `count_out` hold until a cycle with `count_ack`=1. `count_valid` is 0 in the following cycle. The next ARMED entry clears `count_out`.
- Edge and idle match in the same cycle: the edge wins. It counts, resets the idle counter, and the FSM stays in COUNTING.
- `step_in` held high: one edge only. Minimum resolvable step is 1 cycle high plus 1 cycle low.
- `rst` mid-burst: all state returns to the reset values on the next edge, and the partial count is lost.

## Configuration
- `BURST_MON_SYNC_EN`:
  - Defined: `step_in` passes through a 2-flop synchronizer (reset 0) before edge detection, which adds 2 cycles to the edge latency. Use this for asynchronous or off-board pulse sources.
  - Undefined: `step_in` feeds edge detection directly and must already be synchronous to `clk`.

## Structure
- Shared package `burst_mon_pkg`:
  - FSM state enum `{IDLE, ARMED, COUNTING, DONE}`.
  - `IDLE_CNT_W = 8`.
  - Default values for `CW` and `IDLE_CYC`.
- Sub-module `rise_edge_detect` holds the optional synchronizer and the `prev` register, with output `edge`. The top level holds the FSM, the step counter, the idle counter and the output registers.

## Test plan
- **Nominal burst:** reset, `arm`=1, 8 pulses (1 high/1 low), defaults → `count_valid` 5 cycles after the last edge, `count_out`=8, `overflow`=0; ack → ARMED next cycle.
- **Saturation:** 20 pulses with CW=4 → `count_out`=15, `overflow`=1; the next ARMED entry clears `overflow`.
- **Idle boundary:** IDLE_CYC=4. Pulses spaced so a rise lands exactly on the 4th idle cycle → one burst, not split. Spacing of 5 idle cycles → first result reported after the earlier pulses only.
- **Abort:** drop `arm` after 3 pulses in COUNTING → IDLE next cycle, `count_valid` never rises, `busy`=0.
- **Handshake hold:** leave DONE unacked for 10 cycles while pulsing `step_in` → `count_out` is unchanged and `count_valid` stays 1. Ack with `arm`=0 → IDLE.
- **Reset mid-burst:** assert `rst` during COUNTING → every output at its reset value on the next cycle. With `BURST_MON_SYNC_EN` defined, repeat the nominal burst → same count, with `count_valid` 2 cycles later.
